// File: rtl/regfile_writeback_pkg.sv
// wb_pkg: shared widths and FIFO entry type for the register-file writeback path
package wb_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: execute/MDU/decode-facing signals of the writeback controller
// WB_BYPASS_EN adds the forwarding outputs rs1_fwd_hit, rs2_fwd_hit and fwd_data
interface regfile_writeback_if #(parameter int DEPTH = 4);
    import wb_pkg::*;
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_wd;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  mdu_valid;
    logic                  mdu_ready;
    logic [REG_ADDR_W-1:0] mdu_rd;
    logic [XLEN-1:0]       mdu_wd;
    logic [REG_ADDR_W-1:0] q_rs1;
    logic [REG_ADDR_W-1:0] q_rs2;
    logic [REG_ADDR_W-1:0] q_rd;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  rd_busy;
    logic                  alu_stall;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef WB_BYPASS_EN
    logic                  rs1_fwd_hit;
    logic                  rs2_fwd_hit;
    logic [XLEN-1:0]       fwd_data;
`endif
    modport slave (
        input  alu_valid, alu_rd, alu_wd, issue_valid, issue_rd, mdu_valid, mdu_rd, mdu_wd,
               q_rs1, q_rs2, q_rd,
        output mdu_ready, rs1_busy, rs2_busy, rd_busy, alu_stall, reg_write, rd, wd, fifo_count
`ifdef WB_BYPASS_EN
        , output rs1_fwd_hit, rs2_fwd_hit, fwd_data
`endif
    );
    modport master (
        output alu_valid, alu_rd, alu_wd, issue_valid, issue_rd, mdu_valid, mdu_rd, mdu_wd,
               q_rs1, q_rs2, q_rd,
        input  mdu_ready, rs1_busy, rs2_busy, rd_busy, alu_stall, reg_write, rd, wd, fifo_count
`ifdef WB_BYPASS_EN
        , input rs1_fwd_hit, rs2_fwd_hit, fwd_data
`endif
    );
endinterface

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: DEPTH-entry circular FIFO of writeback entries with occupancy count
module wb_fifo import wb_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              din,
    input  logic                   pop,
    output wb_entry_t              dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) if (push) mem[wp] <= din;
    assign dout = mem[rp];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: regfile write-port arbiter (ALU > MDU FIFO), busy scoreboard and starvation guard
// WB_BYPASS_EN: busy clears at the pop edge and writeback data is forwarded to decode
module regfile_writeback import wb_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic clk,
    input logic rst,
    regfile_writeback_if.slave wb
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    wb_entry_t head;
    logic full, empty, alu_win, pop, push, set, clr;
    logic [REG_ADDR_W-1:0] clr_rd;
    logic [NUM_REGS-1:0] busy, busy_next;
    logic [SW-1:0] starve;
    assign alu_win = wb.alu_valid && wb.alu_rd != '0;
    assign pop = !alu_win && !empty;
    assign wb.mdu_ready = !rst && !full;
    assign push = wb.mdu_valid && wb.mdu_ready && wb.mdu_rd != '0;
    assign set = wb.issue_valid && wb.issue_rd != '0;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .din({wb.mdu_rd, wb.mdu_wd}), .pop(pop),
        .dout(head), .full(full), .empty(empty), .count(wb.fifo_count)
    );
`ifdef WB_BYPASS_EN
    assign clr = pop;
    assign clr_rd = head.rd;
    assign wb.rs1_fwd_hit = wb.reg_write && wb.rd != '0 && wb.rd == wb.q_rs1;
    assign wb.rs2_fwd_hit = wb.reg_write && wb.rd != '0 && wb.rd == wb.q_rs2;
    assign wb.fwd_data = wb.wd;
`else
    // marks a reg_write cycle sourced from the FIFO; busy drops when the regfile captures it
    logic fifo_wb;
    always_ff @(posedge clk) fifo_wb <= !rst && pop;
    assign clr = fifo_wb;
    assign clr_rd = wb.rd;
`endif
    always_comb begin
        busy_next = busy;
        if (clr) busy_next[clr_rd] = 1'b0;
        if (set) busy_next[wb.issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end
    assign wb.rs1_busy = busy[wb.q_rs1];
    assign wb.rs2_busy = busy[wb.q_rs2];
    assign wb.rd_busy = busy[wb.q_rd];
    always_ff @(posedge clk) begin
        if (rst) begin
            wb.reg_write <= 1'b0;
            wb.rd <= '0;
            wb.wd <= '0;
            busy <= '0;
            starve <= '0;
            wb.alu_stall <= 1'b0;
        end else begin
            wb.reg_write <= alu_win || pop;
            if (alu_win) begin
                wb.rd <= wb.alu_rd;
                wb.wd <= wb.alu_wd;
            end else if (pop) begin
                wb.rd <= head.rd;
                wb.wd <= head.wd;
            end
            busy <= busy_next;
            starve <= pop ? '0 : (!empty && alu_win && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;
            wb.alu_stall <= pop ? 1'b0 : (starve == SW'(STARVE_LIMIT)) ? 1'b1 : wb.alu_stall;
        end
    end
    always_ff @(posedge clk)
        if (!rst) assert (!(wb.alu_valid && wb.alu_stall)) else $error("alu_valid asserted while alu_stall is high");
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed and randomized checks of regfile_writeback against a queue-based model
module tb_regfile_writeback;
    import wb_pkg::*;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    regfile_writeback_if #(.DEPTH(DEPTH)) bus();
    regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .wb(bus));
    int checks = 0;
    int errors = 0;
    wb_entry_t mq[$];
    bit [31:0] mb;
    bit m_rw, m_ff, m_stall;
    logic [4:0] m_rd;
    logic [31:0] m_wd;
    int m_sc;
    int n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        mq.delete();
        mb = '0;
        m_rw = 0;
        m_ff = 0;
        m_stall = 0;
        m_rd = '0;
        m_wd = '0;
        m_sc = 0;
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_wd = '0;
        bus.issue_valid = 0; bus.issue_rd = '0;
        bus.mdu_valid = 0; bus.mdu_rd = '0; bus.mdu_wd = '0;
    endtask

    // compare every output with the model, advance the model by one clock, then cross the edge
    task automatic step();
        bit aw, pp, hs, dc, st;
        logic [4:0] cr;
        wb_entry_t e;
        #1;
        chk("mdu_ready", 32'(bus.mdu_ready), 32'(!rst && mq.size() < DEPTH));
        chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
        chk("reg_write", 32'(bus.reg_write), 32'(m_rw));
        chk("rd", 32'(bus.rd), 32'(m_rd));
        chk("wd", bus.wd, m_wd);
        chk("alu_stall", 32'(bus.alu_stall), 32'(m_stall));
        chk("rs1_busy", 32'(bus.rs1_busy), 32'(mb[bus.q_rs1]));
        chk("rs2_busy", 32'(bus.rs2_busy), 32'(mb[bus.q_rs2]));
        chk("rd_busy", 32'(bus.rd_busy), 32'(mb[bus.q_rd]));
`ifdef WB_BYPASS_EN
        chk("rs1_fwd", 32'(bus.rs1_fwd_hit), 32'(m_rw && m_rd != 0 && m_rd == bus.q_rs1));
        chk("rs2_fwd", 32'(bus.rs2_fwd_hit), 32'(m_rw && m_rd != 0 && m_rd == bus.q_rs2));
        chk("fwd_data", bus.fwd_data, m_wd);
`endif
        if (rst) mreset();
        else begin
            aw = bus.alu_valid && bus.alu_rd != 0;
            pp = !aw && mq.size() > 0;
            hs = bus.mdu_valid && mq.size() < DEPTH;
`ifdef WB_BYPASS_EN
            dc = pp;
            cr = pp ? mq[0].rd : 5'd0;
`else
            dc = m_ff;
            cr = m_rd;
`endif
            st = pp ? 1'b0 : (m_sc == LIMIT) ? 1'b1 : m_stall;
            if (pp) m_sc = 0;
            else if (mq.size() > 0 && aw && m_sc < LIMIT) m_sc++;
            m_stall = st;
            m_ff = pp;
            if (aw) begin
                m_rw = 1; m_rd = bus.alu_rd; m_wd = bus.alu_wd;
            end else if (pp) begin
                e = mq.pop_front();
                m_rw = 1; m_rd = e.rd; m_wd = e.wd;
            end else m_rw = 0;
            if (hs && bus.mdu_rd != 0) mq.push_back('{rd: bus.mdu_rd, wd: bus.mdu_wd});
            if (dc) mb[cr] = 0;
            if (bus.issue_valid) mb[bus.issue_rd] = 1;
            mb[0] = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        bus.q_rs1 = '0; bus.q_rs2 = '0; bus.q_rd = '0;
        @(posedge clk);
        #1;
        mreset();
        step();
        rst = 0;
        step();
        // ALU only
        bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_wd = 32'h11;
        step();
        chk("alu_rw", 32'(bus.reg_write), 1);
        chk("alu_rd", 32'(bus.rd), 3);
        chk("alu_wd", bus.wd, 32'h11);
        bus.alu_rd = 5'd0; bus.alu_wd = 32'h99;
        step();
        chk("alu_x0_rw", 32'(bus.reg_write), 0);
        chk("alu_x0_hold", 32'(bus.rd), 3);
        // MDU latency
        idle(); bus.issue_valid = 1; bus.issue_rd = 5'd7;
        step();
        idle(); bus.q_rs1 = 5'd7; bus.mdu_valid = 1; bus.mdu_rd = 5'd7; bus.mdu_wd = 32'h2A;
        step();
        chk("mdu_busy7", 32'(bus.rs1_busy), 1);
        chk("mdu_lat1_rw", 32'(bus.reg_write), 0);
        idle();
        step();
        chk("mdu_lat2_rw", 32'(bus.reg_write), 1);
        chk("mdu_lat2_rd", 32'(bus.rd), 7);
        chk("mdu_lat2_wd", bus.wd, 32'h2A);
        step();
        step();
        chk("mdu_busy7_clr", 32'(bus.rs1_busy), 0);
        // ALU/MDU collision
        idle(); bus.mdu_valid = 1; bus.mdu_rd = 5'd9; bus.mdu_wd = 32'h99;
        step();
        idle(); bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_wd = 32'h55;
        step();
        chk("coll_alu_rd", 32'(bus.rd), 5);
        chk("coll_cnt1", 32'(bus.fifo_count), 1);
        idle();
        step();
        chk("coll_mdu_rd", 32'(bus.rd), 9);
        chk("coll_mdu_wd", bus.wd, 32'h99);
        chk("coll_cnt0", 32'(bus.fifo_count), 0);
        // full FIFO under continuous ALU traffic, then starvation stall and drain
        for (int k = 0; k < DEPTH; k++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(20 + k); bus.alu_wd = $urandom;
            bus.mdu_valid = 1; bus.mdu_rd = 5'(11 + k); bus.mdu_wd = 32'h100 + 32'(k);
            step();
        end
        bus.mdu_rd = 5'd30; bus.mdu_wd = 32'h300;
        #1;
        chk("full_ready", 32'(bus.mdu_ready), 0);
        chk("full_cnt", 32'(bus.fifo_count), 4);
        n = 0;
        while (!m_stall && n < 20) begin
            bus.alu_rd = 5'($urandom_range(1, 31)); bus.alu_wd = $urandom;
            step();
            n++;
        end
        chk("starve_stall", 32'(bus.alu_stall), 1);
        chk("starve_cycles", 32'(n), 6);
        bus.alu_valid = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) bus.mdu_valid = 0;
            step();
            chk("drain_rd", 32'(bus.rd), (k < 4) ? 32'(11 + k) : 32'd30);
        end
        // same-edge set and clear of x10
        idle(); bus.issue_valid = 1; bus.issue_rd = 5'd10;
        step();
        idle(); bus.mdu_valid = 1; bus.mdu_rd = 5'd10; bus.mdu_wd = 32'hA0;
        step();
        idle(); bus.issue_valid = 1; bus.issue_rd = 5'd10;
        step();
        step();
        idle(); bus.q_rd = 5'd10;
        #1;
        chk("race_busy10", 32'(bus.rd_busy), 1);
        step();
        // reset mid-run
        idle(); bus.issue_valid = 1; bus.issue_rd = 5'd4;
        step();
        for (int k = 0; k < 3; k++) begin
            idle(); bus.alu_valid = 1; bus.alu_rd = 5'd6; bus.alu_wd = $urandom;
            bus.mdu_valid = 1; bus.mdu_rd = 5'(16 + k); bus.mdu_wd = $urandom;
            step();
        end
        chk("rst_pre_cnt", 32'(bus.fifo_count), 3);
        idle(); bus.q_rd = 5'd4;
        rst = 1;
        step();
        rst = 0;
        chk("rst_cnt", 32'(bus.fifo_count), 0);
        chk("rst_rw", 32'(bus.reg_write), 0);
        chk("rst_busy4", 32'(bus.rd_busy), 0);
        for (int i = 0; i < 11; i++) begin
            bus.q_rs1 = 5'(3 * i); bus.q_rs2 = 5'(3 * i + 1); bus.q_rd = 5'(3 * i + 2);
            step();
        end
        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.alu_valid = !m_stall && ($urandom_range(0, 2) != 0);
            bus.alu_rd = 5'($urandom);
            bus.alu_wd = $urandom;
            bus.issue_valid = ($urandom_range(0, 1) != 0);
            bus.issue_rd = 5'($urandom_range(0, 7));
            bus.mdu_valid = ($urandom_range(0, 1) != 0);
            bus.mdu_rd = 5'($urandom_range(0, 7));
            bus.mdu_wd = $urandom;
            bus.q_rs1 = 5'($urandom_range(0, 7));
            bus.q_rs2 = 5'($urandom_range(0, 7));
            bus.q_rd = 5'($urandom_range(0, 7));
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
